// File: rtl/bram_pkg.sv
// Shared types and elaboration-time checks for the ping-pong frame store.
// Pure declarations: no latency and no backpressure of its own.
package bram_pkg;

    typedef enum logic {BANK_FREE, BANK_FULL} bank_state_e;

    // True when an address of addr_bits bits can reach every word of a bank.
    function automatic bit addr_bits_ok(input int depth, input int addr_bits);
        return (depth >= 1) && (addr_bits >= 1) && (addr_bits < 31) &&
               ((1 << addr_bits) >= depth);
    endfunction

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port block RAM: one write port, one registered read port.
// Read data appears one clock after rd_en; no backpressure, every strobe is taken.
module bram_sdp #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 784,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data
);

    (* ram_style = "block" *) logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // No reset on the array or the output register so the tools map it to block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/bram_pingpong_buffer.sv
// Two-bank ping-pong frame store with commit/release ownership handover.
// Read latency 1 cycle; producer stalls via wr_ready, consumer gated by rd_frame_valid.
module bram_pingpong_buffer
    import bram_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 784,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 wr_commit,
    output logic                 wr_ready,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 rd_valid,
    input  logic                 rd_release,
    output logic                 rd_frame_valid,
    output logic                 err_wr_drop,
    output logic                 err_rd_drop
);

    localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS + 1)'(DEPTH);

    if (!addr_bits_ok(DEPTH, ADDR_BITS)) begin : g_bad_params
        $error("bram_pingpong_buffer: ADDR_BITS too small for DEPTH");
    end

    bank_state_e bank_q [2];
    bank_state_e bank_d [2];
    logic        wr_sel_q, wr_sel_d;
    logic        rd_sel_q, rd_sel_d;
    logic        rd_valid_q, rd_valid_d;
    logic        rd_bank_q, rd_bank_d;
    logic        rd_primed_q, rd_primed_d;
    logic        err_wr_q, err_wr_d;
    logic        err_rd_q, err_rd_d;

    logic             wr_acc;
    logic             commit_acc;
    logic             rd_acc;
    logic             release_acc;
    logic [1:0]       bank_we;
    logic [1:0]       bank_re;
    logic [WIDTH-1:0] bank_rdata [2];

    always_comb begin
        wr_ready       = (bank_q[wr_sel_q] == BANK_FREE);
        rd_frame_valid = (bank_q[rd_sel_q] == BANK_FULL);

        wr_acc      = wr_en && wr_ready && ({1'b0, wr_addr} < DEPTH_W);
        commit_acc  = wr_commit && wr_ready;
        rd_acc      = rd_en && rd_frame_valid && ({1'b0, rd_addr} < DEPTH_W);
        release_acc = rd_release && rd_frame_valid;

        bank_we = {wr_acc && wr_sel_q, wr_acc && !wr_sel_q};
        bank_re = {rd_acc && rd_sel_q, rd_acc && !rd_sel_q};
    end

    // Commit and release always touch different banks: one is FREE, the other FULL.
    always_comb begin
        bank_d[0]   = bank_q[0];
        bank_d[1]   = bank_q[1];
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        rd_valid_d  = rd_acc;
        rd_bank_d   = rd_bank_q;
        rd_primed_d = rd_primed_q || rd_acc;
        err_wr_d    = err_wr_q || (wr_en && !wr_acc) || (wr_commit && !wr_ready);
        err_rd_d    = err_rd_q || (rd_en && !rd_acc) || (rd_release && !rd_frame_valid);

        if (commit_acc) begin
            bank_d[wr_sel_q] = BANK_FULL;
            wr_sel_d         = !wr_sel_q;
        end
        if (release_acc) begin
            bank_d[rd_sel_q] = BANK_FREE;
            rd_sel_d         = !rd_sel_q;
        end
        if (rd_acc) begin
            rd_bank_d = rd_sel_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q[0]   <= BANK_FREE;
            bank_q[1]   <= BANK_FREE;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_primed_q <= 1'b0;
            err_wr_q    <= 1'b0;
            err_rd_q    <= 1'b0;
        end else begin
            bank_q[0]   <= bank_d[0];
            bank_q[1]   <= bank_d[1];
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            rd_valid_q  <= rd_valid_d;
            rd_bank_q   <= rd_bank_d;
            rd_primed_q <= rd_primed_d;
            err_wr_q    <= err_wr_d;
            err_rd_q    <= err_rd_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        bram_sdp #(
            .WIDTH     (WIDTH),
            .DEPTH     (DEPTH),
            .ADDR_BITS (ADDR_BITS)
        ) u_ram (
            .clk     (clk),
            .wr_en   (bank_we[b]),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rd_en   (bank_re[b]),
            .rd_addr (rd_addr),
            .rd_data (bank_rdata[b])
        );
    end

    // A RAM output register only moves on an accepted read of its bank, so the
    // mux holds rd_data between reads; it reads zero until the first read after reset.
    assign rd_data        = rd_primed_q ? bank_rdata[rd_bank_q] : '0;
    assign rd_valid       = rd_valid_q;
    assign err_wr_drop    = err_wr_q;
    assign err_rd_drop    = err_rd_q;

endmodule

// File: tb/tb_bram_pingpong_buffer.sv
// Scoreboard bench: a frame-FIFO reference model predicts every cycle's outputs,
// a monitor pops and compares after each clock edge.
module tb_bram_pingpong_buffer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 784;
    localparam int AB    = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [AB-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             wr_commit;
    logic             wr_ready;
    logic             rd_en;
    logic [AB-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_release;
    logic             rd_frame_valid;
    logic             err_wr_drop;
    logic             err_rd_drop;

    bram_pingpong_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_BITS(AB)) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_commit      (wr_commit),
        .wr_ready       (wr_ready),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .rd_release     (rd_release),
        .rd_frame_valid (rd_frame_valid),
        .err_wr_drop    (err_wr_drop),
        .err_rd_drop    (err_rd_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         vld;
        logic [7:0] dat;
        bit         wrdy;
        bit         rfv;
        bit         ew;
        bit         er;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: committed frames form a FIFO of depth 2 over two storage slots.
    int         m_cnt;
    int         m_head;
    logic [7:0] m_store [2][DEPTH];
    bit         m_ew;
    bit         m_er;
    logic [7:0] m_last;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, expv, $time);
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_head = 0;
        m_ew   = 1'b0;
        m_er   = 1'b0;
        m_last = 8'h00;
    endtask

    task automatic idle_inputs();
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        wr_commit  = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        rd_release = 1'b0;
    endtask

    task automatic cycle(input bit we, input int wa, input logic [7:0] wd, input bit wc,
                         input bit re, input int ra, input bit rr);
        exp_t e;
        bit   wrdy, rfv, wacc, racc;
        int   ws;
        @(negedge clk);
        wr_en      = we;
        wr_addr    = AB'(wa);
        wr_data    = wd;
        wr_commit  = wc;
        rd_en      = re;
        rd_addr    = AB'(ra);
        rd_release = rr;

        wrdy = (m_cnt < 2);
        rfv  = (m_cnt > 0);
        ws   = (m_head + m_cnt) % 2;
        wacc = we && wrdy && (wa < DEPTH);
        racc = re && rfv && (ra < DEPTH);
        if ((we && !wacc) || (wc && !wrdy)) m_ew = 1'b1;
        if ((re && !racc) || (rr && !rfv)) m_er = 1'b1;
        if (racc) m_last = m_store[m_head][ra];
        if (wacc) m_store[ws][wa] = wd;
        if (wc && wrdy) m_cnt++;
        if (rr && rfv) begin
            m_head = (m_head + 1) % 2;
            m_cnt--;
        end

        e.vld  = racc;
        e.dat  = m_last;
        e.wrdy = (m_cnt < 2);
        e.rfv  = (m_cnt > 0);
        e.ew   = m_ew;
        e.er   = m_er;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
        chk({tag, "_rd_frame_valid"}, 32'(rd_frame_valid), 32'd0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        chk({tag, "_err_wr_drop"}, 32'(err_wr_drop), 32'd0);
        chk({tag, "_err_rd_drop"}, 32'(err_rd_drop), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
    endtask

    task automatic fill_frame(input bit use_addr, input logic [7:0] val);
        for (int a = 0; a < DEPTH; a++)
            cycle(1'b1, a, use_addr ? 8'(a) : val, 1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rd_valid", 32'(rd_valid), 32'(e.vld));
                chk("rd_data", 32'(rd_data), 32'(e.dat));
                chk("wr_ready", 32'(wr_ready), 32'(e.wrdy));
                chk("rd_frame_valid", 32'(rd_frame_valid), 32'(e.rfv));
                chk("err_wr_drop", 32'(err_wr_drop), 32'(e.ew));
                chk("err_rd_drop", 32'(err_rd_drop), 32'(e.er));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst = 1'b1;
        idle_inputs();
        model_reset();
        do_reset();

        // Frame of address-valued data, commit, then one read of address 5.
        fill_frame(1'b1, 8'h00);
        cycle(1'b0, 0, 8'h00, 1'b1, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 8'h00, 1'b0, 1'b1, 5, 1'b0);
        cycle(1'b0, 0, 8'h00, 1'b0, 1'b0, 0, 1'b0);

        // Two committed frames: producer stalls, dropped write leaves data intact.
        do_reset();
        fill_frame(1'b0, 8'hAA);
        cycle(1'b0, 0, 8'h00, 1'b1, 1'b0, 0, 1'b0);
        fill_frame(1'b0, 8'h55);
        cycle(1'b0, 0, 8'h00, 1'b1, 1'b0, 0, 1'b0);
        cycle(1'b1, 7, 8'h11, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 8'h00, 1'b0, 1'b1, 7, 1'b0);
        cycle(1'b0, 0, 8'h00, 1'b0, 1'b0, 0, 1'b1);
        cycle(1'b0, 0, 8'h00, 1'b0, 1'b1, 7, 1'b0);

        // Write+commit and read+release in one cycle, then read back the new frame.
        cycle(1'b1, 3, 8'h77, 1'b1, 1'b1, 3, 1'b1);
        cycle(1'b0, 0, 8'h00, 1'b0, 1'b1, 3, 1'b0);

        // Randomised traffic with occasional out-of-range addresses.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 10) < 6,
                  ($urandom % 30 == 0) ? DEPTH + int'($urandom % 200) : int'($urandom % DEPTH),
                  8'($urandom),
                  ($urandom % 60) == 0,
                  ($urandom % 2) == 1,
                  ($urandom % 30 == 0) ? DEPTH + int'($urandom % 200) : int'($urandom % DEPTH),
                  ($urandom % 60) == 0);
        end

        // Read and release with nothing committed.
        do_reset();
        cycle(1'b0, 0, 8'h00, 1'b0, 1'b1, 4, 1'b1);
        cycle(1'b0, 0, 8'h00, 1'b0, 1'b0, 0, 1'b0);

        // Out-of-range write and read addresses.
        do_reset();
        cycle(1'b1, 800, 8'h3C, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 8'h00, 1'b1, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 8'h00, 1'b0, 1'b1, 900, 1'b0);

        // Asynchronous reset between edges with a read response pending.
        cycle(1'b1, 10, 8'h5A, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b1, 11, 8'h5B, 1'b0, 1'b1, 10, 1'b0);
        @(posedge clk);
        #3;
        idle_inputs();
        rst = 1'b1;
        model_reset();
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, 0, 8'h00, 1'b0, 1'b0, 0, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
